// File: rtl/jtag_csr_pkg.sv
// jtag_csr_pkg: shared widths, encodings and register-select enum for the JTAG CSR data registers
package jtag_csr_pkg;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;
    localparam logic RW_WR = 1'b0;
    localparam logic RW_RD = 1'b1;
    localparam logic [ADDR_W-1:0] ADDR_RST = 3'b001;
    typedef enum logic [1:0] {
        SEL_BYPASS = 2'd0,
        SEL_ADDR   = 2'd1,
        SEL_DATA   = 2'd2
    } dr_sel_e;
endpackage

// File: rtl/jtag_dr_chain.sv
// jtag_dr_chain: one test data register with shift register, saturating bit counter, update register and in-flight valid
module jtag_dr_chain #(
    parameter int W = 8,
    parameter int CNT_W = 6,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         tck,
    input  logic         tck_rst,
    input  logic         tdi,
    input  logic         capture,
    input  logic         shift,
    input  logic         update,
    input  logic [W-1:0] cap_val,
    output logic         sr0,
    output logic [W-1:0] par,
    output logic         valid
);
    logic [W-1:0]     sr;
    logic [CNT_W-1:0] cnt;
    assign sr0 = sr[0];
    // capture/shift/update sequencing; reset only reinitialises par when no pass is in flight
    always_ff @(posedge tck) begin
        if (tck_rst) begin
            sr    <= '0;
            cnt   <= '0;
            valid <= 1'b0;
            if (!valid) par <= RST_VAL;
        end else if (capture) begin
            sr    <= cap_val;
            cnt   <= '0;
            valid <= 1'b1;
        end else if (shift) begin
            sr  <= {tdi, sr[W-1:1]};
            cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
        end else if (update) begin
            valid <= 1'b0;
            if (cnt == CNT_W'(W)) par <= sr;
        end
    end
endmodule

// File: rtl/jtag_csr_dr.sv
// jtag_csr_dr: CSR ADDR/DATA test data registers plus BYPASS with tdo mux, clocked by TCK
module jtag_csr_dr
    import jtag_csr_pkg::*;
(
    input  logic              tck,
    input  logic              tck_rst,
    input  logic              tdi,
    input  logic              sel_addr,
    input  logic              sel_data,
    input  logic              capture_dr,
    input  logic              shift_dr,
    input  logic              update_dr,
    input  logic [ADDR_W-1:0] csr_addr,
    input  logic [DATA_W-1:0] csr_data,
    output logic              tdo,
    output logic              dr_csr_addr_valid,
    output logic              dr_csr_data_valid,
    output logic [ADDR_W-1:0] dr_csr_addr,
    output logic [DATA_W-1:0] dr_csr_data
);
    dr_sel_e sel;
    logic    addr_sr0, data_sr0, bypass;
    assign sel = sel_addr ? SEL_ADDR : sel_data ? SEL_DATA : SEL_BYPASS;
    jtag_dr_chain #(.W(ADDR_W), .CNT_W(CNT_W), .RST_VAL(ADDR_RST)) u_addr (
        .tck(tck), .tck_rst(tck_rst), .tdi(tdi),
        .capture(capture_dr && sel == SEL_ADDR),
        .shift(shift_dr && sel == SEL_ADDR),
        .update(update_dr && sel == SEL_ADDR),
        .cap_val(csr_addr), .sr0(addr_sr0), .par(dr_csr_addr), .valid(dr_csr_addr_valid)
    );
    jtag_dr_chain #(.W(DATA_W), .CNT_W(CNT_W), .RST_VAL('0)) u_data (
        .tck(tck), .tck_rst(tck_rst), .tdi(tdi),
        .capture(capture_dr && sel == SEL_DATA),
        .shift(shift_dr && sel == SEL_DATA),
        .update(update_dr && sel == SEL_DATA),
        .cap_val(csr_data), .sr0(data_sr0), .par(dr_csr_data), .valid(dr_csr_data_valid)
    );
    // single-bit bypass register: cleared on capture, follows tdi on shift
    always_ff @(posedge tck) begin
        if (tck_rst) bypass <= 1'b0;
        else if (capture_dr && sel == SEL_BYPASS) bypass <= 1'b0;
        else if (shift_dr && sel == SEL_BYPASS) bypass <= tdi;
    end
    // tdo follows the LSB of whichever register the IR selects
    always_comb begin
        tdo = sel == SEL_ADDR ? addr_sr0 : sel == SEL_DATA ? data_sr0 : bypass;
    end
endmodule

// File: tb/tb_jtag_csr_dr.sv
// tb_jtag_csr_dr: randomized and directed passes checked against a pass-level reference model
module tb_jtag_csr_dr;
    import jtag_csr_pkg::*;
    logic tck = 1'b0;
    logic tck_rst, tdi, sel_addr, sel_data, capture_dr, shift_dr, update_dr;
    logic [ADDR_W-1:0] csr_addr, dr_csr_addr;
    logic [DATA_W-1:0] csr_data, dr_csr_data;
    logic tdo, dr_csr_addr_valid, dr_csr_data_valid;
    int n_cmp = 0, n_err = 0;
    logic [ADDR_W-1:0] m_pa;
    logic [DATA_W-1:0] m_pd;
    bit m_va, m_vd;

    jtag_csr_dr dut (
        .tck(tck), .tck_rst(tck_rst), .tdi(tdi), .sel_addr(sel_addr), .sel_data(sel_data),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
        .csr_addr(csr_addr), .csr_data(csr_data), .tdo(tdo),
        .dr_csr_addr_valid(dr_csr_addr_valid), .dr_csr_data_valid(dr_csr_data_valid),
        .dr_csr_addr(dr_csr_addr), .dr_csr_data(dr_csr_data)
    );

    always #5 tck = ~tck;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge tck);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, " addr_valid"}, dr_csr_addr_valid, m_va);
        chk({tag, " data_valid"}, dr_csr_data_valid, m_vd);
        chk({tag, " dr_csr_addr"}, dr_csr_addr, m_pa);
        chk({tag, " dr_csr_data"}, dr_csr_data, m_pd);
    endtask

    task automatic do_reset;
        tck_rst = 1'b1;
        tick();
        tck_rst = 1'b0;
        if (!m_va) m_pa = ADDR_RST;
        if (!m_vd) m_pd = '0;
        m_va = 0;
        m_vd = 0;
        check_all("reset");
        chk("reset tdo", tdo, 1'b0);
    endtask

    // one full DR pass: capture, n shifts of bits (LSB first), update; optional reset after rst_at shifts
    task automatic pass(input bit d, input int n, input logic [127:0] bits,
                        input logic [31:0] cap, input int rst_at);
        int w;
        w = d ? DATA_W : ADDR_W;
        sel_addr = !d;
        sel_data = d;
        if (d) csr_data = cap;
        else csr_addr = cap[ADDR_W-1:0];
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        if (d) m_vd = 1;
        else m_va = 1;
        check_all("capture");
        for (int i = 0; i < n; i++) begin
            chk(d ? "data tdo" : "addr tdo", tdo, i < w ? cap[i] : bits[i-w]);
            shift_dr = 1'b1;
            tdi = bits[i];
            tick();
            shift_dr = 1'b0;
            check_all("shift");
            if (i + 1 == rst_at) begin
                do_reset();
                sel_addr = 1'b0;
                sel_data = 1'b0;
                tick();
                tick();
                return;
            end
        end
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
        if (n == w) begin
            if (d) m_pd = bits[DATA_W-1:0];
            else m_pa = bits[ADDR_W-1:0];
        end
        if (d) m_vd = 0;
        else m_va = 0;
        check_all("update");
        sel_addr = 1'b0;
        sel_data = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic [127:0] rb;
        logic [2:0] byp;
        int n, w;
        bit d;
        tck_rst = 1'b1; tdi = 0; sel_addr = 0; sel_data = 0;
        capture_dr = 0; shift_dr = 0; update_dr = 0; csr_addr = '0; csr_data = '0;
        m_pa = 'x; m_pd = 'x; m_va = 0; m_vd = 0;
        tick();
        do_reset();
        tick();
        check_all("idle");
        chk("idle tdo", tdo, 1'b0);

        pass(0, 3, 128'b010, 32'h7, -1);
        pass(1, 32, 128'hDEADBEEF, 32'h12345678, -1);
        pass(1, 31, {$urandom, $urandom, $urandom, $urandom}, 32'hA5A5A5A5, -1);
        pass(1, 33, {$urandom, $urandom, $urandom, $urandom}, 32'h5A5A5A5A, -1);
        pass(1, 96, {$urandom, $urandom, $urandom, $urandom}, 32'h0F0F0F0F, -1);
        pass(0, 64, {$urandom, $urandom, $urandom, $urandom}, 32'h2, -1);
        pass(1, 32, {$urandom, $urandom, $urandom, $urandom}, $urandom, 10);

        byp = 3'b101;
        sel_addr = 0;
        sel_data = 0;
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        chk("bypass capture tdo", tdo, 1'b0);
        for (int i = 0; i < 3; i++) begin
            shift_dr = 1'b1;
            tdi = byp[2-i];
            tick();
            shift_dr = 1'b0;
            chk("bypass tdo", tdo, byp[2-i]);
            check_all("bypass");
        end
        tick();

        for (int k = 0; k < 30; k++) begin
            d = 1'($urandom_range(0, 1));
            w = d ? DATA_W : ADDR_W;
            case ($urandom_range(0, 3))
                0: n = w - 1;
                1: n = w + 1;
                2: n = $urandom_range(0, 70);
                default: n = w;
            endcase
            rb = {$urandom, $urandom, $urandom, $urandom};
            pass(d, n, rb, $urandom, ($urandom_range(0, 5) == 0 && n > 0) ? $urandom_range(1, n) : -1);
        end

        do_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
